// File: rtl/layer_sequencer.sv
// Layer sequencer: walks the network stage by stage and issues one Height/Width/Depth iteration per unstalled cycle.
// Build option GLOBAL_MAXPOOL_EN inserts a Global_MaxPool stage between CONV1D_3rd and FC_1st.
//
// state | meaning
// IDLE  | after reset, waiting for Start
// RUN   | issuing iterations of the current stage
// DRAIN | idle window between stages (Compute_stage = 0)
// DONE  | network finished, All_done held until Start
module layer_sequencer #(
    parameter int CONV1_W_LAST = 183,
    parameter int CONV1_D_LAST = 15,
    parameter int POOL_W_LAST  = 91,
    parameter int POOL_D_LAST  = 15,
    parameter int CONV2_W_LAST = 87,
    parameter int CONV2_D_LAST = 15,
    parameter int CONV3_W_LAST = 83,
    parameter int CONV3_D_LAST = 31,
    parameter int FC1_D_LAST   = 31,
    parameter int FC2_D_LAST   = 0,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Stall,
    output logic [8:0] Compute_stage,
    output logic [3:0] Height,
    output logic [4:0] Depth,
    output logic [8:0] Width,
    output logic       Busy,
    output logic       Stage_done,
    output logic       All_done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    typedef enum logic [2:0] {S_CONV1, S_POOL, S_CONV2, S_CONV3, S_GMAX, S_FC1, S_FC2} stage_t;

    localparam int FC1_W_LAST = 6;
    localparam int FC2_W_LAST = 3;

    function automatic bit in_range(input int v, input int hi);
        in_range = (v >= 0) && (v <= hi);
    endfunction

    localparam bit PARAMS_OK =
        in_range(CONV1_W_LAST, 511) && in_range(CONV1_D_LAST, 31) &&
        in_range(POOL_W_LAST, 511)  && in_range(POOL_D_LAST, 31)  &&
        in_range(CONV2_W_LAST, 511) && in_range(CONV2_D_LAST, 31) &&
        in_range(CONV3_W_LAST, 511) && in_range(CONV3_D_LAST, 31) &&
        in_range(FC1_D_LAST, 31)    && in_range(FC2_D_LAST, 31)   &&
        (DRAIN_CYCLES >= 1) && (DRAIN_CYCLES <= 15);

    param_range_chk : assert property (@(posedge Clk) PARAMS_OK)
        else $error("layer_sequencer: parameter out of range");

    function automatic logic [8:0] code_of(input stage_t s);
        case (s)
            S_CONV1: code_of = 9'b001000000;
            S_POOL:  code_of = 9'b000100000;
            S_CONV2: code_of = 9'b000010000;
            S_CONV3: code_of = 9'b000001000;
            S_GMAX:  code_of = 9'b000000100;
            S_FC1:   code_of = 9'b000000010;
            default: code_of = 9'b000000001;
        endcase
    endfunction

    function automatic logic [3:0] h_last(input stage_t s);
        case (s)
            S_CONV2: h_last = 4'd7;
            S_CONV3: h_last = 4'd15;
            default: h_last = 4'd0;
        endcase
    endfunction

    function automatic logic [8:0] w_last(input stage_t s);
        case (s)
            S_CONV1:         w_last = 9'(CONV1_W_LAST);
            S_POOL:          w_last = 9'(POOL_W_LAST);
            S_CONV2:         w_last = 9'(CONV2_W_LAST);
            S_CONV3, S_GMAX: w_last = 9'(CONV3_W_LAST);
            S_FC1:           w_last = 9'(FC1_W_LAST);
            default:         w_last = 9'(FC2_W_LAST);
        endcase
    endfunction

    function automatic logic [4:0] d_last(input stage_t s);
        case (s)
            S_CONV1:         d_last = 5'(CONV1_D_LAST);
            S_POOL:          d_last = 5'(POOL_D_LAST);
            S_CONV2:         d_last = 5'(CONV2_D_LAST);
            S_CONV3, S_GMAX: d_last = 5'(CONV3_D_LAST);
            S_FC1:           d_last = 5'(FC1_D_LAST);
            default:         d_last = 5'(FC2_D_LAST);
        endcase
    endfunction

    // Global_MaxPool and the FC layers sweep Width innermost with Height pinned at 0.
    function automatic logic width_inner(input stage_t s);
        width_inner = (s == S_GMAX) || (s == S_FC1) || (s == S_FC2);
    endfunction

    function automatic stage_t next_stage(input stage_t s);
        case (s)
            S_CONV1: next_stage = S_POOL;
            S_POOL:  next_stage = S_CONV2;
            S_CONV2: next_stage = S_CONV3;
`ifdef GLOBAL_MAXPOOL_EN
            S_CONV3: next_stage = S_GMAX;
`else
            S_CONV3: next_stage = S_FC1;
`endif
            S_GMAX:  next_stage = S_FC1;
            default: next_stage = S_FC2;
        endcase
    endfunction

    state_t     state_q, state_nx;
    stage_t     stage_q, stage_nx;
    logic [8:0] code_q, code_nx;
    logic [3:0] h_q, h_nx;
    logic [8:0] w_q, w_nx;
    logic [4:0] d_q, d_nx;
    logic [3:0] drain_q, drain_nx;
    logic       busy_q, busy_nx;
    logic       sdone_q, sdone_nx;
    logic       adone_q, adone_nx;

    logic h_wrap, w_wrap, d_wrap, last_iter;

    assign h_wrap    = (h_q == h_last(stage_q));
    assign w_wrap    = (w_q == w_last(stage_q));
    assign d_wrap    = (d_q == d_last(stage_q));
    assign last_iter = h_wrap && w_wrap && d_wrap;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            stage_q <= S_CONV1;
            code_q  <= '0;
            h_q     <= '0;
            w_q     <= '0;
            d_q     <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            sdone_q <= 1'b0;
            adone_q <= 1'b0;
        end else begin
            state_q <= state_nx;
            stage_q <= stage_nx;
            code_q  <= code_nx;
            h_q     <= h_nx;
            w_q     <= w_nx;
            d_q     <= d_nx;
            drain_q <= drain_nx;
            busy_q  <= busy_nx;
            sdone_q <= sdone_nx;
            adone_q <= adone_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        stage_nx = stage_q;
        code_nx  = code_q;
        h_nx     = h_q;
        w_nx     = w_q;
        d_nx     = d_q;
        drain_nx = drain_q;
        busy_nx  = busy_q;
        sdone_nx = sdone_q;
        adone_nx = adone_q;

        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    state_nx = RUN;
                    stage_nx = S_CONV1;
                    code_nx  = code_of(S_CONV1);
                    h_nx     = '0;
                    w_nx     = '0;
                    d_nx     = '0;
                    busy_nx  = 1'b1;
                    sdone_nx = 1'b0;
                    adone_nx = 1'b0;
                end
            end
            RUN: begin
                if (!Stall) begin
                    if (last_iter) begin
                        state_nx = DRAIN;
                        drain_nx = 4'(DRAIN_CYCLES - 1);
                        code_nx  = '0;
                        h_nx     = '0;
                        w_nx     = '0;
                        d_nx     = '0;
                        sdone_nx = 1'b1;
                    end else if (width_inner(stage_q)) begin
                        h_nx = '0;
                        if (w_wrap) begin
                            w_nx = '0;
                            d_nx = d_q + 5'd1;
                        end else begin
                            w_nx = w_q + 9'd1;
                        end
                    end else if (!h_wrap) begin
                        h_nx = h_q + 4'd1;
                    end else begin
                        h_nx = '0;
                        if (w_wrap) begin
                            w_nx = '0;
                            d_nx = d_q + 5'd1;
                        end else begin
                            w_nx = w_q + 9'd1;
                        end
                    end
                end
            end
            DRAIN: begin
                if (!Stall) begin
                    sdone_nx = 1'b0;
                    if (drain_q == 4'd0) begin
                        if (stage_q == S_FC2) begin
                            state_nx = DONE;
                            busy_nx  = 1'b0;
                            adone_nx = 1'b1;
                        end else begin
                            state_nx = RUN;
                            stage_nx = next_stage(stage_q);
                            code_nx  = code_of(next_stage(stage_q));
                        end
                    end else begin
                        drain_nx = drain_q - 4'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign Compute_stage = code_q;
    assign Height        = h_q;
    assign Width         = w_q;
    assign Depth         = d_q;
    assign Busy          = busy_q;
    assign Stage_done    = sdone_q;
    assign All_done      = adone_q;

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Upstream controller for the uCode decoder: walks the network layer by layer and generates the per-cycle Compute_stage, Height, Depth and Width loop indices that the decoder turns into pipeline, data-read, data-write and weight-read control words.
- One iteration is issued per unstalled cycle.
- A drain window of idle cycles (Compute_stage = 0) is inserted between stages so the registered decoder and downstream pipeline flush before the next layer starts.

Parameters:
- CONV1_W_LAST, 183, last Width index for CONV1D_1st
- CONV1_D_LAST, 15, last Depth index for CONV1D_1st
- POOL_W_LAST, 91, last Width index for MaxPool
- POOL_D_LAST, 15, last Depth index for MaxPool
- CONV2_W_LAST, 87, last Width index for CONV1D_2nd
- CONV2_D_LAST, 15, last Depth index for CONV1D_2nd
- CONV3_W_LAST, 83, last Width index for CONV1D_3rd
- CONV3_D_LAST, 31, last Depth index for CONV1D_3rd
- FC1_D_LAST, 31, last Depth index for FC_1st
- FC2_D_LAST, 0, last Depth index for FC_2nd
- DRAIN_CYCLES, 8, idle cycles between stages (1..15)

Ports:
- Clk  in  1  clock
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  single-cycle request to run the full network
- Stall  in  1  freeze: hold all indices and state this cycle
- Compute_stage  out  9  one-hot stage code; 0 = idle/drain
- Height  out  4  kernel-tap index
- Depth  out  5  output-channel index
- Width  out  9  position index
- Busy  out  1  high from the cycle after Start accept until DONE
- Stage_done  out  1  one-cycle pulse on the first drain cycle of each stage
- All_done  out  1  high in DONE

Behaviour:
- Reset is asynchronous, active-high. All outputs reset to 0; state resets to IDLE.
- Stage codes:
  - CONV1D_1st = 9'b001000000
  - MaxPool = 9'b000100000
  - CONV1D_2nd = 9'b000010000
  - CONV1D_3rd = 9'b000001000
  - Global_MaxPool = 9'b000000100
  - FC_1st = 9'b000000010
  - FC_2nd = 9'b000000001
- Stage order: CONV1D_1st, MaxPool, CONV1D_2nd, CONV1D_3rd, FC_1st, FC_2nd.
- Height last value is fixed per stage: CONV1D_1st 0, MaxPool 0, CONV1D_2nd 7, CONV1D_3rd 15, FC_1st 0, FC_2nd 0.
- Loop nest:
  - CONV1D_1st, MaxPool, CONV1D_2nd, CONV1D_3rd: Height innermost, then Width, then Depth outermost.
  - FC_1st (Width 0..6) and FC_2nd (Width 0..3): Width innermost, Depth outer, Height held at 0.
- Each counter wraps to 0 when it passes its last value and carries into the next counter out.
- Iterations per stage = (H_LAST+1)*(W_LAST+1)*(D_LAST+1).
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + Start: go to RUN. The next cycle shows the first stage code with all indices 0, Busy=1, All_done=0.
  - RUN, unstalled: advance one iteration per cycle. On the cycle holding the final iteration of a stage, the next state is DRAIN.
  - DRAIN: Compute_stage=0 and indices 0 for DRAIN_CYCLES cycles. Stage_done pulses on drain cycle 1. The cycle after drain ends shows the next stage code with indices 0.
  - After the FC_2nd drain: go to DONE. All_done=1, Busy=0, held until Start or Reset.
- Start asserted while in RUN or DRAIN is ignored.
- Start and Stall in the same IDLE cycle: Start is still accepted; Stall only freezes RUN/DRAIN.
- Stall=1 in RUN or DRAIN holds every output and the drain counter unchanged, including Stage_done. A pulse pending on that cycle is re-presented the following unstalled cycle, so it is seen exactly once per stage.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No partial stage is resumed.
- Widths: Width counter 9 bits, Depth 5 bits, Height 4 bits. Parameters outside those ranges are illegal; the RTL checks them only in simulation.

Optional Feature:
- GLOBAL_MAXPOOL_EN: when defined, a Global_MaxPool stage is inserted between CONV1D_3rd and FC_1st.
  - Width innermost 0..CONV3_W_LAST, Depth 0..CONV3_D_LAST, Height 0.
  - Followed by its own drain window and Stage_done pulse.
- When undefined, the stage is skipped and the Global_MaxPool code is never emitted.

Test Plan:
- Reset released, no Start -> all outputs 0 indefinitely. Start pulse -> the next cycle shows Compute_stage=9'b001000000, H/W/D=0, Busy=1.
- All W_LAST=1, D_LAST=1, DRAIN_CYCLES=2 -> CONV1D_2nd emits 32 iterations: Height 0..7 inner, then Width, then Depth. Exactly 2 zero-stage cycles follow, with Stage_done high on the first.
- Same parameters, full run -> 6 Stage_done pulses, then All_done=1 and Busy=0. Total cycle count is the sum of the iterations plus 6*2 drain cycles.
- Stall held 3 cycles mid-CONV1D_3rd at H=5, W=1, D=0 -> outputs frozen for 3 cycles, then resume at H=6 with no iteration lost or duplicated.
- Reset asserted during FC_1st at Width=4 -> outputs 0 in the same cycle, asynchronously. Start after release -> restarts at CONV1D_1st.
- GLOBAL_MAXPOOL_EN defined -> Compute_stage=9'b000000100 appears between CONV1D_3rd and FC_1st with 4 iterations (W_LAST=1, D_LAST=1), giving 7 Stage_done pulses. Undefined -> the code never appears.
